// File: rtl/mips_defs_pkg.sv
// Shared fetch-stage definitions: reset/NOP constants, fetch FSM states,
// the IF/ID entry layout and a word-alignment helper.
package mips_defs_pkg;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // S_IDLE is only visited for the single cycle after reset.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    // 65-bit IF/ID entry.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    // Instruction fetches are word aligned; drop the byte offset.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: write-enable, flush to a bubble, synchronous reset.
module if_id_reg
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  write_en,
    input  logic  flush,
    input  ifid_t next_entry,
    output ifid_t entry
);

    // Reset and flush both load a bubble; flush overrides a held (stalled) entry.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            entry <= '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};
        end else if (flush) begin
            entry <= '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};
        end else if (write_en) begin
            entry <= next_entry;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the imem req/ack handshake, a
// one-word fetch buffer for stalls, and feeds the IF/ID register.
module if_stage
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        PCWrite_in,
    input  logic        IFIDWrite_in,
    input  logic        FLUSH_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        jmp_in,
    input  logic [31:0] jmp_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] IFIDInstr_out,
    output logic [31:0] IFIDPCPlus4_out,
    output logic        IFIDValid_out
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  fetch_buf;
    logic         req;

    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         advance;
    logic         ifid_load;
    ifid_t        ifid_next;
    ifid_t        ifid_q;

    // Redirect decode: branch beats jump; targets are forced word-aligned.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // can leave it unassigned and infer a latch.
        redirect    = FLUSH_in & (branch_taken_in | jmp_in);
        redirect_pc = align_word(branch_taken_in ? branch_target_in : jmp_target_in);
        // PCWrite without IFIDWrite is not a legal advance; treat it as a stall.
        advance     = PCWrite_in & IFIDWrite_in;
    end

    // A word enters IF/ID on an accepted fetch or on release of a held word.
    always_comb begin
        ifid_load = 1'b0;
        if (!redirect && advance) begin
            ifid_load = ((state == S_REQ) && imem_ack_in) || (state == S_HOLD);
        end
        ifid_next.instr   = (state == S_HOLD) ? fetch_buf : imem_rdata_in;
        ifid_next.pcplus4 = pc + 32'd4;
        ifid_next.valid   = 1'b1;
    end

    // Fetch FSM with registered request, PC and stall buffer.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
            req   <= 1'b0;
            pc    <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                    req   <= 1'b1;
                    if (redirect) pc <= redirect_pc;
                end
                S_REQ: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        // An un-acked request must still be drained before refetching.
                        if (!imem_ack_in) state <= S_DROP;
                    end else if (imem_ack_in) begin
                        if (advance) begin
                            pc <= pc + 32'd4;
                        end else begin
                            state <= S_HOLD;
                            req   <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                        req   <= 1'b1;
                    end else if (advance) begin
                        pc    <= pc + 32'd4;
                        state <= S_REQ;
                        req   <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (redirect) pc <= redirect_pc;
                    if (imem_ack_in) state <= S_REQ;
                end
                default: begin
                    state <= S_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    // Capture the fetched word when the pipeline cannot take it this cycle.
    always_ff @(posedge clk_in) begin
        // NOTE: the buffer is datapath only, always written before S_HOLD
        // reads it, so it carries no reset.
        if ((state == S_REQ) && imem_ack_in && !redirect && !advance) begin
            fetch_buf <= imem_rdata_in;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .write_en   (ifid_load),
        .flush      (FLUSH_in),
        .next_entry (ifid_next),
        .entry      (ifid_q)
    );

    assign imem_req_out    = req;
    assign imem_addr_out   = pc;
    assign IFIDInstr_out   = ifid_q.instr;
    assign IFIDPCPlus4_out = ifid_q.pcplus4;
    assign IFIDValid_out   = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcw, ifw, flush, br, jm, ack;
    logic [31:0] bt, jt, rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instr, ifid_pc4;
    logic        ifid_valid;

    int tests = 0;
    int fails = 0;
    bit auto_imem = 1'b0;

    // Reference model: PC, boot flag, words waiting for the pipeline, and
    // whether the outstanding request's data must be thrown away.
    logic [31:0] m_pc;
    bit          m_booting;
    logic [31:0] m_held[$];
    bit          m_dropping;
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .PCWrite_in       (pcw),
        .IFIDWrite_in     (ifw),
        .FLUSH_in         (flush),
        .branch_taken_in  (br),
        .branch_target_in (bt),
        .jmp_in           (jm),
        .jmp_target_in    (jt),
        .imem_req_out     (imem_req),
        .imem_addr_out    (imem_addr),
        .imem_ack_in      (ack),
        .imem_rdata_in    (rdata),
        .IFIDInstr_out    (ifid_instr),
        .IFIDPCPlus4_out  (ifid_pc4),
        .IFIDValid_out    (ifid_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A request is visible whenever fetching has started and no word is parked.
    function automatic logic m_req();
        return !m_booting && (m_held.size() == 0);
    endfunction

    task automatic model_step();
        logic        redirect, go, got_word;
        logic [31:0] tgt, word, old_pc;
        if (!rst_n) begin
            m_pc = 32'h0; m_booting = 1'b1; m_held.delete(); m_dropping = 1'b0;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            return;
        end
        redirect = flush && (br || jm);
        tgt      = (br ? bt : jt) & 32'hFFFF_FFFC;
        go       = pcw && ifw;
        got_word = 1'b0;
        word     = 32'h0;
        old_pc   = m_pc;
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_held.size() > 0) begin
            if (redirect) m_held.delete();
            else if (go) begin got_word = 1'b1; word = m_held.pop_front(); end
        end else if (ack) begin
            if (m_dropping || redirect) m_dropping = 1'b0;
            else if (go) begin got_word = 1'b1; word = rdata; end
            else m_held.push_back(rdata);
        end else if (redirect) begin
            m_dropping = 1'b1;
        end
        if (redirect) m_pc = tgt;
        else if (got_word) m_pc = old_pc + 32'd4;
        if (flush) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (got_word) begin
            m_instr = word; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
        end
    endtask

    // One clock: present inputs, advance the model, compare on the falling edge.
    task automatic tick();
        if (auto_imem) begin
            ack   = m_req();
            rdata = m_pc | 32'hA000_0000;
        end
        model_step();
        @(negedge clk);
        check("req",   {31'h0, imem_req},   {31'h0, m_req()});
        check("addr",  imem_addr,           m_pc);
        check("instr", ifid_instr,          m_instr);
        check("pc4",   ifid_pc4,            m_pc4);
        check("valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    endtask

    initial begin
        rst_n = 1'b0; pcw = 1'b1; ifw = 1'b1; flush = 1'b0; br = 1'b0; jm = 1'b0;
        bt = 32'h0; jt = 32'h0; ack = 1'b0; rdata = 32'h0;

        // 1: reset then zero-wait streaming
        tick();
        check("t1_rst_req", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1; auto_imem = 1'b1;
        tick();
        check("t1_first_valid", {31'h0, ifid_valid}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("t1_stream", ifid_instr, 32'hA000_0000 + 32'(4 * k));
        end

        // 2: three-cycle stall starting at the ack for address 8
        pcw = 1'b0; ifw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_hold_req", {31'h0, imem_req}, 32'h0);
            check("t2_frozen", ifid_instr, 32'hA000_0004);
        end
        pcw = 1'b1; ifw = 1'b1;
        tick();
        check("t2_release_instr", ifid_instr, 32'hA000_0008);
        check("t2_release_pc4", ifid_pc4, 32'h0000_000C);

        // 3: branch while the fetch of 0x10 is waiting for a late ack
        tick();
        auto_imem = 1'b0; ack = 1'b0;
        flush = 1'b1; br = 1'b1; bt = 32'h0000_0100;
        tick();
        check("t3_bubble", {31'h0, ifid_valid}, 32'h0);
        flush = 1'b0; br = 1'b0;
        tick();
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        check("t3_dropped", {31'h0, ifid_valid}, 32'h0);
        check("t3_new_addr", imem_addr, 32'h0000_0100);
        auto_imem = 1'b1;
        tick();
        check("t3_target", ifid_instr, 32'hA000_0100);

        // 4: branch beats jump; misaligned jump target
        flush = 1'b1; br = 1'b1; bt = 32'h0000_0200; jm = 1'b1; jt = 32'h0000_0300;
        tick();
        check("t4_priority", imem_addr, 32'h0000_0200);
        br = 1'b0; jt = 32'h0000_0303;
        tick();
        check("t4_align", imem_addr, 32'h0000_0300);

        // 5: PC wrap
        jt = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0; jm = 1'b0;
        tick();
        check("t5_pc4_wrap", ifid_pc4, 32'h0);
        check("t5_addr_wrap", imem_addr, 32'h0);
        check("t5_instr", ifid_instr, 32'hFFFF_FFFC);

        // 6: reset from S_DROP and from S_HOLD
        auto_imem = 1'b0; ack = 1'b0; flush = 1'b1; jm = 1'b1; jt = 32'h0000_0040;
        tick();
        flush = 1'b0; jm = 1'b0; rst_n = 1'b0;
        tick();
        check("t6_drop_rst_req", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("t6_drop_restart", imem_addr, 32'h0);
        auto_imem = 1'b1;
        tick();
        pcw = 1'b0; ifw = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("t6_hold_rst_valid", {31'h0, ifid_valid}, 32'h0);
        rst_n = 1'b1; pcw = 1'b1; ifw = 1'b1;
        tick();
        check("t6_hold_restart", {31'h0, imem_req}, 32'h1);

        // Randomized traffic: stalls, illegal stall combos, flushes, redirects,
        // variable imem latency and occasional resets.
        auto_imem = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 199) != 0);
            r = int'($urandom_range(0, 9));
            case (r)
                6:       begin pcw = 1'b0; ifw = 1'b0; end
                7:       begin pcw = 1'b1; ifw = 1'b0; end
                8:       begin pcw = 1'b0; ifw = 1'b1; end
                9:       begin pcw = 1'b0; ifw = 1'b0; end
                default: begin pcw = 1'b1; ifw = 1'b1; end
            endcase
            flush = ($urandom_range(0, 7) == 0);
            br    = 1'($urandom_range(0, 1));
            jm    = 1'($urandom_range(0, 1));
            bt    = $urandom;
            jt    = $urandom;
            ack   = m_req() && ($urandom_range(0, 2) != 0);
            rdata = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
